// File: rtl/fetch_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : fetch_unit_if                                                |
// | Brief  : PC-register, redirect, I-cache and instruction-queue bundle. |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
interface fetch_unit_if;
  // PC register side
  logic [31:0] pc_out;
  logic        pc_load;
  logic [31:0] pc_next;
  // back-end redirect
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // instruction cache
  logic        icache_read;
  logic [31:0] icache_addr;
  logic        icache_resp;
  logic [31:0] icache_rdata;
  // instruction queue towards decode
  logic        iq_valid;
  logic [31:0] iq_pc;
  logic [31:0] iq_instr;
  logic        iq_ready;

  modport master (
    input  pc_out, redirect_valid, redirect_pc, icache_resp, icache_rdata, iq_ready,
    output pc_load, pc_next, icache_read, icache_addr, iq_valid, iq_pc, iq_instr
  );

  modport slave (
    output pc_out, redirect_valid, redirect_pc, icache_resp, icache_rdata, iq_ready,
    input  pc_load, pc_next, icache_read, icache_addr, iq_valid, iq_pc, iq_instr
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : fetch_unit                                                   |
// | Brief  : Single-outstanding I-cache fetcher with redirect flush and   |
// |          a circular {pc, instr} queue feeding decode.                 |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
module fetch_unit #(
  parameter int DEPTH = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  fetch_unit_if.master  bus
);

  localparam int               c_PTR_W     = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_DEPTH_CNT = (c_PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_req_addr;

  logic [31:0]         r_pc_mem    [DEPTH];
  logic [31:0]         r_instr_mem [DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_PTR_W:0]    r_count;

  logic                w_full;
  logic                w_empty;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_pc_load;
  logic [31:0]         w_pc_next;

  assign w_full  = (r_count == c_DEPTH_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && bus.iq_ready && !bus.redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req_addr <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_req_addr <= bus.pc_out;
      end
    end
  end

  // A redirect always wins the PC load, even over a response landing the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    w_pc_load   = 1'b0;
    w_pc_next   = r_req_addr + 32'd4;
    case (r_state)
      S_IDLE: begin
        if (!bus.redirect_valid && !w_full) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.icache_resp) begin
          w_push      = !bus.redirect_valid;
          w_state_nxt = S_IDLE;
        end else if (bus.redirect_valid) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (bus.icache_resp) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_push) begin
      w_pc_load = 1'b1;
    end
    if (bus.redirect_valid) begin
      w_pc_load = 1'b1;
      w_pc_next = bus.redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked solely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_req_addr;
      r_instr_mem[r_wr_ptr] <= bus.icache_rdata;
    end
  end

  assign bus.pc_load     = w_pc_load;
  assign bus.pc_next     = w_pc_next;
  assign bus.icache_read = (r_state != S_IDLE);
  assign bus.icache_addr = r_req_addr;
  assign bus.iq_valid    = !w_empty;
  assign bus.iq_pc       = r_pc_mem[r_rd_ptr];
  assign bus.iq_instr    = r_instr_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : tb_fetch_unit                                                |
// | Brief  : Directed bench for fetch_unit with PC-register and cache.    |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // PC register: resets to 0x60, loads pc_next on pc_load
  logic [31:0] pc_reg;
  always_ff @(posedge clk) begin
    if (rst)              pc_reg <= 32'h0000_0060;
    else if (bus.pc_load) pc_reg <= bus.pc_next;
  end
  assign bus.pc_out = pc_reg;

  // Cache: strobes resp 'lat' cycles after the read first appears
  int   lat;
  int   cnt;
  logic fixed_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.icache_resp <= 1'b0;
      cnt             <= 0;
    end else if (bus.icache_resp) begin
      bus.icache_resp <= 1'b0;
      cnt             <= 0;
    end else if (bus.icache_read) begin
      if (cnt + 1 >= lat) bus.icache_resp <= 1'b1;
      else                cnt             <= cnt + 1;
    end
  end
  assign bus.icache_rdata = fixed_data ? 32'h0000_0013 : ~bus.icache_addr;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got [8];
    int          nresp;

    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.iq_ready       = 1'b1;
    lat                = 1;
    fixed_data         = 1'b1;

    // ---- reset state and basic streaming ----
    do_reset();
    chk("rst_read",    bus.icache_read, 0);
    chk("rst_iqvalid", bus.iq_valid,    0);
    chk("rst_pcload",  bus.pc_load,     0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("s1_read",    bus.icache_read, 1);
      chk("s1_addr",    bus.icache_addr, 32'h60 + 32'(4 * k));
      tick();
      chk("s1_pcload",  bus.pc_load,     1);
      chk("s1_pcnext",  bus.pc_next,     32'h64 + 32'(4 * k));
      tick();
      chk("s1_iqvalid", bus.iq_valid,    1);
      chk("s1_iqpc",    bus.iq_pc,       32'h60 + 32'(4 * k));
      chk("s1_iqinstr", bus.iq_instr,    32'h13);
      chk("s1_idle",    bus.icache_read, 0);
    end

    // ---- back-pressure fills exactly DEPTH entries ----
    fixed_data   = 1'b0;
    bus.iq_ready = 1'b0;
    do_reset();
    nresp = 0;
    for (int t = 0; t < 20; t++) begin
      if (bus.icache_resp) begin
        if (nresp < 8) got[nresp] = bus.icache_addr;
        nresp++;
      end
      tick();
    end
    chk("full_nresp", 32'(nresp), 32'd4);
    for (int i = 0; i < 4; i++) chk("full_addr", got[i], 32'h60 + 32'(4 * i));
    chk("full_read",  bus.icache_read, 0);
    chk("full_valid", bus.iq_valid,    1);
    bus.iq_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_valid", bus.iq_valid, 1);
      chk("drain_pc",    bus.iq_pc,    32'h60 + 32'(4 * i));
      chk("drain_instr", bus.iq_instr, ~(32'h60 + 32'(4 * i)));
      if (i == 2) begin
        chk("resume_read", bus.icache_read, 1);
        chk("resume_addr", bus.icache_addr, 32'h70);
      end
      tick();
    end

    // ---- redirect while waiting, late response dropped ----
    lat = 3;
    do_reset();
    tick();
    chk("r1_addr", bus.icache_addr, 32'h60);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    #1;
    chk("r1_pcload", bus.pc_load, 1);
    chk("r1_pcnext", bus.pc_next, 32'h200);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("r1_iqvalid", bus.iq_valid,    0);
    chk("r1_pcreg",   bus.pc_out,      32'h200);
    chk("r1_hold",    bus.icache_read, 1);
    chk("r1_haddr",   bus.icache_addr, 32'h60);
    tick();
    chk("r1_haddr2",  bus.icache_addr, 32'h60);
    tick();
    chk("r1_resp",    bus.icache_resp, 1);
    chk("r1_noload",  bus.pc_load,     0);
    tick();
    chk("r1_idle",    bus.icache_read, 0);
    chk("r1_empty",   bus.iq_valid,    0);
    tick();
    chk("r1_tread",   bus.icache_read, 1);
    chk("r1_taddr",   bus.icache_addr, 32'h200);

    // ---- redirect coincident with response ----
    for (int t = 0; t < 10 && !bus.icache_resp; t++) tick();
    chk("r2_resp", bus.icache_resp, 1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h400;
    #1;
    chk("r2_pcload", bus.pc_load, 1);
    chk("r2_pcnext", bus.pc_next, 32'h400);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("r2_noenq", bus.iq_valid,    0);
    chk("r2_idle",  bus.icache_read, 0);
    tick();
    chk("r2_tread", bus.icache_read, 1);
    chk("r2_taddr", bus.icache_addr, 32'h400);

    // ---- second redirect while dropping ----
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h480;
    tick();
    bus.redirect_pc = 32'h500;
    #1;
    chk("r3_pcnext", bus.pc_next,     32'h500);
    chk("r3_hold",   bus.icache_read, 1);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("r3_haddr", bus.icache_addr, 32'h400);
    chk("r3_pcreg", bus.pc_out,      32'h500);
    tick();
    chk("r3_resp",   bus.icache_resp, 1);
    chk("r3_noload", bus.pc_load,     0);
    tick();
    chk("r3_idle",  bus.icache_read, 0);
    tick();
    chk("r3_taddr", bus.icache_addr, 32'h500);
    chk("r3_tread", bus.icache_read, 1);

    // ---- flush of a full queue with simultaneous pop ----
    lat          = 1;
    bus.iq_ready = 1'b0;
    for (int t = 0; t < 16; t++) tick();
    chk("f_full_read", bus.icache_read, 0);
    chk("f_head_pc",   bus.iq_pc,       32'h500);
    chk("f_head_ins",  bus.iq_instr,    ~32'h500);
    bus.iq_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h600;
    #1;
    chk("f_pcnext", bus.pc_next, 32'h600);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("f_empty", bus.iq_valid,    0);
    chk("f_idle",  bus.icache_read, 0);
    tick();
    chk("f_taddr", bus.icache_addr, 32'h600);
    tick();
    chk("f_pcnext2", bus.pc_next, 32'h604);
    tick();
    chk("f_newhead", bus.iq_pc, 32'h600);

    // ---- PC wrap past the top of the address space ----
    bus.iq_ready = 1'b0;
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    #1;
    chk("w_pcnext", bus.pc_next, 32'hFFFF_FFFC);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("w_noissue", bus.icache_read, 0);
    tick();
    chk("w_addr", bus.icache_addr, 32'hFFFF_FFFC);
    tick();
    chk("w_pcload", bus.pc_load, 1);
    chk("w_wrap",   bus.pc_next, 32'h0);
    tick();
    chk("w_iqpc",    bus.iq_pc,    32'hFFFF_FFFC);
    chk("w_iqinstr", bus.iq_instr, 32'h3);
    tick();
    chk("w_addr0", bus.icache_addr, 32'h0);
    chk("w_read0", bus.icache_read, 1);

    // ---- reset mid-fetch ----
    rst = 1'b1;
    #1;
    chk("rm_pcload", bus.pc_load, 0);
    tick();
    chk("rm_read",  bus.icache_read, 0);
    chk("rm_valid", bus.iq_valid,    0);
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
